// File: rtl/sized_data_memory.sv
// Byte-addressed data memory for MIPS lb/lbu/lh/lhu/lw/sb/sh/sw with a registered read,
// misalignment flagging and a sequential clear engine. Optional per-byte parity: DMEM_PARITY_EN.
module sized_data_memory #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] CLR_VALUE  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel,
    input  logic                  str,
    input  logic                  ld,
    input  logic                  clr,
    input  logic [1:0]            size,
    input  logic                  uns,
    input  logic [ADDR_WIDTH+1:0] addr,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  rd_valid,
    output logic                  misaligned,
    output logic                  busy
`ifdef DMEM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] cnt, cnt_next;

    logic [31:0]           mem [DEPTH];

    logic [ADDR_WIDTH-1:0] word;
    logic [1:0]            lane;
    logic [31:0]           rd_word;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  idle_req;
    logic                  bad_align;
    logic                  do_store;
    logic                  do_load;
    logic                  do_mis;

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] ln);
        case (sz)
            2'b00:   lane_mask = 4'b0001 << ln;
            2'b01:   lane_mask = ln[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] ln, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{ln, 3'b000} +: 8];
        h = ln[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   load_extend = u ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   load_extend = u ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_extend = w;
        endcase
    endfunction

    assign word    = addr[ADDR_WIDTH+1:2];
    assign lane    = addr[1:0];
    assign rd_word = mem[word];
    assign be      = lane_mask(size, lane);
    assign wdata   = lane_data(size, data_in);
    assign busy    = (state == CLEAR);

    // clr wins over any request in the same cycle; nothing is accepted while clearing
    assign idle_req  = (state == IDLE) && sel && !clr;
    assign bad_align = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                       (size == 2'b10 && addr[1:0] != 2'b00);
    assign do_store  = idle_req && str && !bad_align;
    assign do_load   = idle_req && ld && !str && !bad_align;
    assign do_mis    = idle_req && (str || ld) && bad_align;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt + ADDR_WIDTH'(1);
                if (&cnt) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            data_out   <= '0;
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            rd_valid   <= do_load;
            misaligned <= do_mis;
            if (do_load) data_out <= load_extend(rd_word, size, lane, uns);
        end
    end

    // array has no reset; a reset during CLEAR simply stops further writes
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= CLR_VALUE;
        end else if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] par_mem [DEPTH];

    function automatic logic [3:0] par4(input logic [31:0] w);
        for (int i = 0; i < 4; i++) par4[i] = ^w[8*i +: 8];
    endfunction

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            par_mem[cnt] <= par4(CLR_VALUE);
        end else if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) par_mem[word][i] <= ^wdata[8*i +: 8];
            end
        end
    end

    // only the lanes touched by the load are checked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err <= 1'b0;
        else        parity_err <= do_load && |(be & (par4(rd_word) ^ par_mem[word]));
    end
`endif

endmodule

// File: doc/sized_data_memory.md
Name: sized_data_memory

Overview:
Parametrised successor to the single-cycle CPU data memory, serving MIPS lb/lbu/lh/lhu/lw/sb/sh/sw.
- Byte-addressed with per-size byte lanes and sign/zero extension.
- Registered read with a valid strobe and misalignment detection.
- Multi-cycle sequential clear engine with a busy flag.
- Sits between the datapath's ALU address output and the write-back mux.

Parameters:
ADDR_WIDTH, 10, word-address bits; DEPTH = 2**ADDR_WIDTH 32-bit words.
CLR_VALUE, 32'h0000_0000, word written to every location by the clear engine.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
sel  in  1  chip select; no request is accepted when 0.
str  in  1  store request.
ld  in  1  load request.
clr  in  1  start sequential clear (sampled, level-triggered).
size  in  2  00 byte, 01 half, 10 word, 11 reserved.
uns  in  1  loads: 1 zero-extend, 0 sign-extend.
addr  in  ADDR_WIDTH+2  byte address; addr[1:0] is the byte lane.
data_in  in  32  store data, right-justified.
data_out  out  32  load result, registered.
rd_valid  out  1  one-cycle pulse, data_out updated.
misaligned  out  1  one-cycle pulse, request rejected.
busy  out  1  clear engine running.

Behaviour:
- Reset (rst_n=0, async):
  - data_out=0, rd_valid=0, misaligned=0, busy=0, FSM=IDLE, clear counter=0.
  - Memory array is NOT reset.
- FSM states:
  - IDLE: accepts requests.
  - CLEAR: writes CLR_VALUE to word cnt each cycle, cnt 0..DEPTH-1. busy=1 from the cycle after clr is sampled through the final write. Then returns to IDLE, so busy is high exactly DEPTH cycles.
  - rst_n low mid-CLEAR aborts immediately; already-cleared words stay cleared.
- Request decode (IDLE only, sel=1):
  - str&!ld: store. !str&ld: load. str&ld: store only, no rd_valid. Neither: no-op.
- Priority in IDLE: clr beats str/ld in the same cycle; the request is dropped and no flags are raised.
- While busy: str/ld/clr ignored (no write, no rd_valid, no misaligned).
- Alignment:
  - Half with addr[0]=1, word with addr[1:0]!=0, or size=11: misaligned=1 next cycle.
  - No write; data_out unchanged; rd_valid=0.
- Lanes (little-endian, lane k = bits 8k+7:8k):
  - sb writes data_in[7:0] to lane addr[1:0].
  - sh writes data_in[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - sw writes all lanes.
  - Unselected lanes are preserved.
- Loads:
  - Latency 1: request in cycle N gives data_out and rd_valid=1 in cycle N+1.
  - Byte/half extracted from the addressed lane(s), then sign- or zero-extended per uns.
  - data_out holds its last value when rd_valid=0; never tri-stated.
- Read-after-write: a load in cycle N+1 to a word stored in cycle N returns the new data.
- Address wraps naturally within DEPTH; no out-of-range condition exists.

Optional Feature:
DMEM_PARITY_EN
- Defined:
  - One even-parity bit is stored per byte and written alongside each data byte, including by CLEAR.
  - Loads check parity of the accessed bytes only.
  - Extra output port parity_err (1 bit, reset 0) pulses with rd_valid on a mismatch; data_out is still delivered.
- Undefined: no parity storage and no parity_err port.

Test Plan:
- Reset then sw addr=0x028 data=0xDEADBEEF; lw 0x028 -> next cycle data_out=0xDEADBEEF, rd_valid=1 for exactly one cycle.
- After the above, sb addr=0x029 data=0x80; lb 0x029 -> 0xFFFFFF80; lbu 0x029 -> 0x00000080; lw 0x028 -> 0xDEAD80EF.
- sh addr=0x052 data=0xCAFE; lh 0x052 -> 0xFFFFCAFE; lhu -> 0x0000CAFE; lw 0x050 -> upper half 0xCAFE, lower half unchanged.
- lw addr=0x02A and sh addr=0x051 -> misaligned pulse, rd_valid=0, memory and data_out unchanged.
- Pulse clr with str asserted the same cycle -> store dropped, busy high exactly 1024 cycles, str/ld ignored meanwhile. Afterwards lw 0x028 -> 0x00000000.
- Assert rst_n=0 at clear cycle 100 -> busy=0 immediately. Word 5 reads 0, word 500 keeps its prior value. With DMEM_PARITY_EN, forcing a stored parity bit gives a parity_err pulse with rd_valid.
